rf_datapath: RTL and testbench

RF_DATAPATH -- requirements
Module: rf_datapath

---
 rtl/rf_datapath_if.sv | 35 +++
 rtl/rf_datapath.sv | 111 +++++++++++
 tb/tb_rf_datapath.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_datapath_if
// Description : Control, status and output-stream bundle for rf_datapath.
//               The master side drives register-file controls and out_ready;
//               the slave side (the datapath) returns status and FIFO data.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_datapath_if #(
    parameter int DATA_W = 8
);
    logic              RFSrcMuxSel;
    logic [2:0]        r_addr_1;
    logic [2:0]        r_addr_2;
    logic [2:0]        wr_addr;
    logic              wr_en;
    logic              OutPortEn;
    logic              R1Le10;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              fifo_full;
    logic [7:0]        drop_cnt;

    modport master (
        output RFSrcMuxSel, r_addr_1, r_addr_2, wr_addr, wr_en, OutPortEn, out_ready,
        input  R1Le10, out_data, out_valid, fifo_full, drop_cnt
    );

    modport slave (
        input  RFSrcMuxSel, r_addr_1, r_addr_2, wr_addr, wr_en, OutPortEn, out_ready,
        output R1Le10, out_data, out_valid, fifo_full, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rf_datapath.sv
`default_nettype none
// ============================================================================
// Module      : rf_datapath
// Description : 8-entry register file with adder write-back path, an
//               RF[1] <= LIMIT status flag and a registered output FIFO
//               that counts (saturating) pushes rejected while full.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_datapath #(
    parameter int DATA_W     = 8,
    parameter int LIMIT      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    rf_datapath_if.slave bus
);
    localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] c_LIMIT = DATA_W'(LIMIT);
    localparam logic [DATA_W-1:0] c_ONE   = DATA_W'(1);

    logic [DATA_W-1:0]  r_rf [0:7];
    logic [DATA_W-1:0]  r_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_drop_cnt;

    logic [DATA_W-1:0]  w_rd1;
    logic [DATA_W-1:0]  w_rd2;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Read ports, adder and write-data select; address 0 is hard-wired to zero.
    always_comb begin
        w_rd1   = (bus.r_addr_1 == 3'd0) ? '0 : r_rf[bus.r_addr_1];
        w_rd2   = (bus.r_addr_2 == 3'd0) ? '0 : r_rf[bus.r_addr_2];
        w_sum   = w_rd1 + w_rd2;
        w_wdata = bus.RFSrcMuxSel ? c_ONE : w_sum;
    end

    // FIFO handshake: a pop frees a slot, so a push into a full FIFO is
    // accepted in the same cycle as a pop and dropped otherwise.
    always_comb begin
        w_full  = (r_count == c_FULL);
        w_valid = (r_count != '0);
        w_pop   = w_valid && bus.out_ready;
        w_push  = bus.OutPortEn && (!w_full || w_pop);
        w_drop  = bus.OutPortEn && w_full && !w_pop;
    end

    // Register file; entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != 3'd0)) begin
            r_rf[bus.wr_addr] <= w_wdata;
        end
    end

    // FIFO storage; contents are meaningless until the count says otherwise.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rd1;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Status and output-stream drive.
    always_comb begin
        bus.R1Le10    = (r_rf[1] <= c_LIMIT);
        bus.out_data  = r_mem[r_rd_ptr];
        bus.out_valid = w_valid;
        bus.fifo_full = w_full;
        bus.drop_cnt  = r_drop_cnt;
    end
endmodule
`default_nettype wire

// File: tb/tb_rf_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_datapath
// Description : Directed self-checking bench for rf_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_datapath;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    bit   cap_en;
    logic [7:0] got[$];

    rf_datapath_if #(.DATA_W(8)) ifc ();

    rf_datapath #(.DATA_W(8), .LIMIT(10), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every entry that leaves the FIFO, sampled mid-cycle.
    always @(negedge clk) begin
        if (cap_en && ifc.out_valid && ifc.out_ready) begin
            got.push_back(ifc.out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply one cycle of controls, return 1 time unit after the rising edge.
    task automatic step(input logic sel, input logic [2:0] a1, input logic [2:0] a2,
                        input logic [2:0] wa, input logic we, input logic pe, input logic rdy);
        ifc.RFSrcMuxSel = sel;
        ifc.r_addr_1    = a1;
        ifc.r_addr_2    = a2;
        ifc.wr_addr     = wa;
        ifc.wr_en       = we;
        ifc.OutPortEn   = pe;
        ifc.out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;
    endtask

    // Build a value in a zeroed register by shift-and-add, using R7 as scratch.
    task automatic build(input logic [2:0] addr, input logic [7:0] value);
        step(1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (value[i]) step(1'b0, addr, 3'd7, addr, 1'b1, 1'b0, 1'b0);
            step(1'b0, 3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Triangular-number program: R2 += R1, R1 += R3, push R2.
    task automatic run_program(input logic rdy);
        int r1;
        r1 = 0;
        step(1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, rdy);
        step(1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, rdy);
        step(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, rdy);
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0, rdy);
            step(1'b0, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0, rdy);
            r1++;
            check($sformatf("prog_r1le10_%0d", r1), {31'd0, ifc.R1Le10}, (r1 <= 10) ? 1 : 0);
            step(1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, rdy);
        end
    endtask

    initial begin
        logic [7:0] exp_tri [0:10];
        logic [7:0] exp_wrap [0:3];
        exp_tri  = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45, 8'd55};
        exp_wrap = '{8'd3, 8'd4, 8'd5, 8'd6};
        n_total = 0;
        n_bad   = 0;
        cap_en  = 1'b0;
        rst     = 1'b1;
        ifc.RFSrcMuxSel = 1'b0;
        ifc.r_addr_1    = '0;
        ifc.r_addr_2    = '0;
        ifc.wr_addr     = '0;
        ifc.wr_en       = 1'b0;
        ifc.OutPortEn   = 1'b0;
        ifc.out_ready   = 1'b0;
        #1;
        check("rst_valid", {31'd0, ifc.out_valid}, 0);
        check("rst_full",  {31'd0, ifc.fifo_full}, 0);
        check("rst_drop",  {24'd0, ifc.drop_cnt}, 0);
        check("rst_r1le",  {31'd0, ifc.R1Le10}, 1);
        do_reset();

        // Program with a free-running consumer.
        got.delete();
        cap_en = 1'b1;
        run_program(1'b1);
        idle(4, 1'b1);
        cap_en = 1'b0;
        check("tri_count", got.size(), 11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("tri_%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_tri[i]});
        end
        check("tri_drop", {24'd0, ifc.drop_cnt}, 0);

        // Program with a stalled consumer, then drain.
        do_reset();
        run_program(1'b0);
        check("stall_full", {31'd0, ifc.fifo_full}, 1);
        check("stall_drop", {24'd0, ifc.drop_cnt}, 7);
        check("stall_head", {24'd0, ifc.out_data}, 0);
        got.delete();
        cap_en = 1'b1;
        idle(6, 1'b1);
        cap_en = 1'b0;
        check("stall_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_tri[i]});
        end
        check("stall_empty", {31'd0, ifc.out_valid}, 0);

        // Writes to address 0 are ignored.
        do_reset();
        step(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("r0_valid", {31'd0, ifc.out_valid}, 1);
        check("r0_data",  {24'd0, ifc.out_data}, 0);

        // 200 + 100 wraps to 44; also boundary on the status flag.
        do_reset();
        build(3'd1, 8'd10);
        check("r1_eq_10", {31'd0, ifc.R1Le10}, 1);
        do_reset();
        build(3'd1, 8'd200);
        build(3'd2, 8'd100);
        check("r1_200", {31'd0, ifc.R1Le10}, 0);
        step(1'b0, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("sum_wrap", {24'd0, ifc.out_data}, 44);

        // Full FIFO: drop, then simultaneous push/pop across pointer wrap.
        do_reset();
        step(1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
        for (int r = 3; r <= 6; r++) step(1'b0, 3'(r - 1), 3'd1, 3'(r), 1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 4; r++) step(1'b0, 3'(r), 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("ff_full", {31'd0, ifc.fifo_full}, 1);
        step(1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("ff_drop1", {24'd0, ifc.drop_cnt}, 1);
        check("ff_head1", {24'd0, ifc.out_data}, 1);
        step(1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        check("ff_still_full", {31'd0, ifc.fifo_full}, 1);
        check("ff_drop_same", {24'd0, ifc.drop_cnt}, 1);
        got.delete();
        cap_en = 1'b1;
        idle(6, 1'b1);
        cap_en = 1'b0;
        check("ff_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ff_%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_wrap[i]});
        end

        // Drop counter saturation.
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("drop_sat", {24'd0, ifc.drop_cnt}, 255);

        // Asynchronous reset with entries queued and RF[1]=11.
        do_reset();
        build(3'd1, 8'd11);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        ifc.OutPortEn = 1'b0;
        check("pre_rst_valid", {31'd0, ifc.out_valid}, 1);
        check("pre_rst_r1le",  {31'd0, ifc.R1Le10}, 0);
        #2 rst = 1'b1;
        #1;
        check("async_valid", {31'd0, ifc.out_valid}, 0);
        check("async_r1le",  {31'd0, ifc.R1Le10}, 1);
        check("async_drop",  {24'd0, ifc.drop_cnt}, 0);
        #1 rst = 1'b0;
        step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("first_push", {31'd0, ifc.out_valid}, 1);
        step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        check("first_pop", {31'd0, ifc.out_valid}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
